branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Tracks every conditional branch predicted in fetch until it resolves in execute, checks the prediction, and produces the predictor training update, the front-end redirect and the pipeline flush. Sits between the gshare predictor in F and the branch comparator in E: F pushes prediction metadata, E pops and resolves it in program order. It is the single source of `update`/`redirect` for the front end.

## Interface
- `GBIT`, 10, PHT index width; must match the predictor
- `DEPTH`, 4, in-flight branch queue entries; power of two, ≥ 2
- `i_clk`  in  1  clock
- `i_rst`  in  1  synchronous reset, active-high
- `i_pred_valid`  in  1  F holds a conditional branch this cycle
- `i_pred_pc`  in  32  branch PC
- `i_pred_taken`  in  1  predicted direction
- `i_pred_idx`  in  GBIT  PHT index used for the prediction
- `i_pred_target`  in  32  predicted taken target
- `i_ex_valid`  in  1  oldest in-flight branch resolves this cycle
- `i_ex_taken`  in  1  actual direction
- `i_ex_target`  in  32  actual taken target
- `o_full`  out  1  queue full; F must stall
- `o_update_en`  out  1  one-cycle training strobe to predictor
- `o_update_idx`  out  GBIT  PHT index to train
- `o_update_taken`  out  1  actual direction
- `o_redirect`  out  1  one-cycle mispredict redirect
- `o_redirect_pc`  out  32  correct next PC
- `o_flush`  out  1  flush F/D/E younger instructions (equals `o_redirect`)
- `o_err`  out  1  sticky: resolve with empty queue
- `o_br_cnt`  out  32  resolved-branch counter
- `o_mis_cnt`  out  32  mispredict counter

## Operation
- Queue: FIFO of entries {pc, taken, idx, target}; write/read pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and rest equal; empty = equal.
- Push when `i_pred_valid & ~o_full & ~drop`; `drop` = mispredict detected this cycle OR `o_redirect` high (wrong-path fetch).
- Resolve when `i_ex_valid & ~o_redirect`: pop head; head-vs-actual compare:
  - mispredict = `taken != i_ex_taken` OR (`i_ex_taken` AND `target != i_ex_target`).
  - correct PC = `i_ex_taken ? i_ex_target : pc + 4` (32-bit, wraps).
- Every resolve: `o_update_en`=1, idx/taken from entry/actual, `o_br_cnt`+1.
- Mispredict: also `o_redirect`=`o_flush`=1, `o_redirect_pc`=correct PC, `o_mis_cnt`+1, entire queue cleared (all younger entries are wrong-path).
- Resolve with empty queue: no pop, no update, no redirect, `o_err` set until reset.
- `i_ex_valid` while `o_redirect` high: ignored (flushed instruction).
- Counters wrap at 2^32.
- No FSM beyond queue pointers; `o_err` is a one-bit sticky state.

## Timing
- All outputs registered; update/redirect appear the cycle after the resolving `i_ex_valid` and last exactly one cycle.
- `o_full` reflects state after the last edge (combinational from pointers, no input path).
- Simultaneous push and non-mispredict pop: both take effect; count unchanged; push allowed even when full at start of cycle only if `~o_full` (no bypass).
- Simultaneous push and mispredict: push dropped, queue empty next cycle.
- Reset: pointers 0, queue empty, `o_full`=0, `o_update_en`=0, `o_update_idx`=0, `o_update_taken`=0, `o_redirect`=`o_flush`=0, `o_redirect_pc`=0, `o_err`=0, counters 0. Reset mid-operation discards all entries and any pending strobe.

## Structure
- Package `bp_pkg`: `bp_entry_t` struct {pc, taken, idx, target}, `GBIT` default, opcode constant `OP_BRANCH = 7'b1100011`.
- One sub-module: `bp_fifo` (parameterised synchronous FIFO with clear, full/empty, storing `bp_entry_t`).

## Test plan
- Reset, push pc=0x100 taken=1 idx=0x3A target=0x140; resolve taken=1 target=0x140 -> next cycle `o_update_en`=1 idx=0x3A taken=1, `o_redirect`=0, br_cnt=1.
- Push pc=0x200 taken=0; resolve taken=1 target=0x280 -> `o_redirect`=`o_flush`=1, redirect_pc=0x280, mis_cnt=1, queue empty.
- Push pc=0x300 taken=1 target=0x340; resolve taken=0 -> redirect_pc=0x304; same-cycle push of pc=0x308 dropped; push in redirect cycle also dropped.
- Push DEPTH=4 entries -> `o_full`=1, fifth push ignored; pop one with simultaneous push -> stays full, FIFO order preserved over 3 pointer wraps.
- `i_ex_valid` with empty queue -> `o_err`=1 sticky, no update strobe, counters unchanged.
- Fill 3 entries, assert `i_rst` one cycle -> all outputs at reset values, next resolve sets `o_err`.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve unit.
//   GBIT       default PHT index width (matches the gshare predictor)
//   IDX_W      storage width of the index field inside a queue entry
//   OP_BRANCH  RISC-V conditional-branch major opcode
//   bp_entry_t one in-flight branch: {pc, taken, idx, target}
package bp_pkg;
  localparam int GBIT  = 10;
  localparam int IDX_W = 32;  // wide enough for any GBIT override; top slices it
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0]      pc;
    logic             taken;
    logic [IDX_W-1:0] idx;
    logic [31:0]      target;
  } bp_entry_t;
endpackage

// File: rtl/bp_fifo.sv
// Synchronous FIFO of bp_entry_t with a one-cycle clear.
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_clr         drop every entry (pointers back to 0); wins over push/pop
//   i_push/i_din  write one entry when not full
//   i_pop         retire the head entry when not empty
//   o_head        current head entry (valid when ~o_empty)
//   o_full/o_empty occupancy flags, pure functions of the pointers
module bp_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_clr,
  input  logic      i_push,
  input  bp_entry_t i_din,
  input  logic      i_pop,
  output bp_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);
  localparam int AW = $clog2(DEPTH);

  bp_entry_t      r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;

  // Extra MSB on each pointer separates full from empty when the low bits match.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + 1'b1;
      if (i_pop  && !o_empty) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads an entry the pointers say is absent.
  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks predicted conditional branches from fetch until execute resolves them
// in order, then emits predictor training, front-end redirect and flush.
//   i_pred_*   F-stage prediction metadata push (pc, direction, PHT idx, target)
//   i_ex_*     E-stage resolution of the oldest in-flight branch
//   o_full     queue full, F must stall (pointer-derived, no input path)
//   o_update_* one-cycle training strobe with PHT idx and actual direction
//   o_redirect/o_flush/o_redirect_pc  one-cycle mispredict redirect
//   o_err      sticky: a resolve arrived with nothing in flight
//   o_br_cnt/o_mis_cnt  resolved / mispredicted branch counters (wrap)
module branch_resolve_unit
  import bp_pkg::*;
#(
  parameter int GBIT  = bp_pkg::GBIT,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pred_valid,
  input  logic [31:0]     i_pred_pc,
  input  logic            i_pred_taken,
  input  logic [GBIT-1:0] i_pred_idx,
  input  logic [31:0]     i_pred_target,
  input  logic            i_ex_valid,
  input  logic            i_ex_taken,
  input  logic [31:0]     i_ex_target,
  output logic            o_full,
  output logic            o_update_en,
  output logic [GBIT-1:0] o_update_idx,
  output logic            o_update_taken,
  output logic            o_redirect,
  output logic [31:0]     o_redirect_pc,
  output logic            o_flush,
  output logic            o_err,
  output logic [31:0]     o_br_cnt,
  output logic [31:0]     o_mis_cnt
);
  bp_entry_t   w_din;
  bp_entry_t   w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_pop_req;
  logic        w_resolve;
  logic        w_mis;
  logic        w_drop;
  logic        w_push;
  logic [31:0] w_correct_pc;

  logic            r_update_en;
  logic [GBIT-1:0] r_update_idx;
  logic            r_update_taken;
  logic            r_redirect;
  logic [31:0]     r_redirect_pc;
  logic            r_err;
  logic [31:0]     r_br_cnt;
  logic [31:0]     r_mis_cnt;

  always_comb begin
    w_din        = '0;
    w_din.pc     = i_pred_pc;
    w_din.taken  = i_pred_taken;
    w_din.idx    = IDX_W'(i_pred_idx);
    w_din.target = i_pred_target;
  end

  // While a redirect is out, E is holding a flushed instruction: ignore it.
  assign w_pop_req    = i_ex_valid && !r_redirect;
  assign w_resolve    = w_pop_req && !w_empty;
  assign w_mis        = w_resolve &&
                        ((w_head.taken != i_ex_taken) ||
                         (i_ex_taken && (w_head.target != i_ex_target)));
  assign w_correct_pc = i_ex_taken ? i_ex_target : (w_head.pc + 32'd4);
  // Anything fetched in a mispredict or redirect cycle is wrong-path.
  assign w_drop       = w_mis || r_redirect;
  assign w_push       = i_pred_valid && !w_full && !w_drop;

  bp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (w_mis),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_resolve),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_update_en    <= 1'b0;
      r_update_idx   <= '0;
      r_update_taken <= 1'b0;
      r_redirect     <= 1'b0;
      r_redirect_pc  <= '0;
      r_err          <= 1'b0;
      r_br_cnt       <= '0;
      r_mis_cnt      <= '0;
    end else begin
      r_update_en <= w_resolve;
      r_redirect  <= w_mis;
      if (w_resolve) begin
        r_update_idx   <= w_head.idx[GBIT-1:0];
        r_update_taken <= i_ex_taken;
        r_br_cnt       <= r_br_cnt + 32'd1;
      end
      if (w_mis) begin
        r_redirect_pc <= w_correct_pc;
        r_mis_cnt     <= r_mis_cnt + 32'd1;
      end
      if (w_pop_req && w_empty) r_err <= 1'b1;
    end
  end

  assign o_full         = w_full;
  assign o_update_en    = r_update_en;
  assign o_update_idx   = r_update_idx;
  assign o_update_taken = r_update_taken;
  assign o_redirect     = r_redirect;
  assign o_flush        = r_redirect;
  assign o_redirect_pc  = r_redirect_pc;
  assign o_err          = r_err;
  assign o_br_cnt       = r_br_cnt;
  assign o_mis_cnt      = r_mis_cnt;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int GBIT  = 10;
  localparam int DEPTH = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_pred_valid;
  logic [31:0]     i_pred_pc;
  logic            i_pred_taken;
  logic [GBIT-1:0] i_pred_idx;
  logic [31:0]     i_pred_target;
  logic            i_ex_valid;
  logic            i_ex_taken;
  logic [31:0]     i_ex_target;
  logic            o_full, o_update_en, o_update_taken, o_redirect, o_flush, o_err;
  logic [GBIT-1:0] o_update_idx;
  logic [31:0]     o_redirect_pc, o_br_cnt, o_mis_cnt;

  branch_resolve_unit #(.GBIT(GBIT), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc), .i_pred_taken(i_pred_taken),
    .i_pred_idx(i_pred_idx), .i_pred_target(i_pred_target),
    .i_ex_valid(i_ex_valid), .i_ex_taken(i_ex_taken), .i_ex_target(i_ex_target),
    .o_full(o_full), .o_update_en(o_update_en), .o_update_idx(o_update_idx),
    .o_update_taken(o_update_taken), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_flush(o_flush), .o_err(o_err), .o_br_cnt(o_br_cnt), .o_mis_cnt(o_mis_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0]     pc;
    logic            taken;
    logic [GBIT-1:0] idx;
    logic [31:0]     target;
  } ent_t;

  typedef struct {
    logic            upd;
    logic [GBIT-1:0] idx;
    logic            tk;
    logic            red;
    logic [31:0]     rpc;
    logic            full;
    logic            err;
    logic [31:0]     br;
    logic [31:0]     mis;
  } exp_t;

  typedef struct {
    logic            pv;
    logic [31:0]     ppc;
    logic            pt;
    logic [GBIT-1:0] pidx;
    logic [31:0]     ptgt;
    logic            ev;
    logic            et;
    logic [31:0]     etgt;
    logic            e_upd;
    logic [GBIT-1:0] e_idx;
    logic            e_tk;
    logic            e_red;
    logic [31:0]     e_rpc;
  } vec_t;

  ent_t        mq[$];
  exp_t        exp_q[$];
  logic        m_red, m_err;
  logic [31:0] m_br, m_mis;
  int          n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model advances on the stimulus, its prediction goes onto the
  // scoreboard, and is popped and compared once the edge has happened.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt,
                      input logic [GBIT-1:0] pidx, input logic [31:0] ptgt,
                      input logic ev, input logic et, input logic [31:0] etgt);
    exp_t e;
    ent_t h;
    logic res, mis;
    int   n;
    n = mq.size();
    e = '{upd:1'b0, idx:'0, tk:1'b0, red:1'b0, rpc:'0, full:1'b0, err:1'b0, br:'0, mis:'0};
    res = ev && !m_red && (n > 0);
    mis = 1'b0;
    if (ev && !m_red && n == 0) m_err = 1'b1;
    if (res) begin
      h = mq[0];
      mis = (h.taken != et) || (et && h.target != etgt);
      e.upd = 1'b1; e.idx = h.idx; e.tk = et;
      m_br = m_br + 32'd1;
      if (mis) begin
        m_mis = m_mis + 32'd1;
        e.red = 1'b1;
        e.rpc = et ? etgt : h.pc + 32'd4;
      end
    end
    if (mis) mq.delete();
    else begin
      if (res) void'(mq.pop_front());
      if (pv && n < DEPTH && !m_red) mq.push_back('{pc:ppc, taken:pt, idx:pidx, target:ptgt});
    end
    m_red  = mis;
    e.full = (mq.size() == DEPTH);
    e.err  = m_err; e.br = m_br; e.mis = m_mis;
    exp_q.push_back(e);

    i_pred_valid = pv; i_pred_pc = ppc; i_pred_taken = pt; i_pred_idx = pidx;
    i_pred_target = ptgt; i_ex_valid = ev; i_ex_taken = et; i_ex_target = etgt;
    @(posedge i_clk); #1;

    e = exp_q.pop_front();
    chk("update_en", 32'(o_update_en), 32'(e.upd));
    if (e.upd) begin
      chk("update_idx",   32'(o_update_idx),   32'(e.idx));
      chk("update_taken", 32'(o_update_taken), 32'(e.tk));
    end
    chk("redirect", 32'(o_redirect), 32'(e.red));
    chk("flush",    32'(o_flush),    32'(e.red));
    if (e.red) chk("redirect_pc", o_redirect_pc, e.rpc);
    chk("full",    32'(o_full), 32'(e.full));
    chk("err",     32'(o_err),  32'(e.err));
    chk("br_cnt",  o_br_cnt,  e.br);
    chk("mis_cnt", o_mis_cnt, e.mis);
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset with a resolve asserted in the same cycle: nothing may leak through.
  task automatic do_reset();
    i_rst = 1'b1; i_pred_valid = 1'b0; i_ex_valid = 1'b1; i_ex_taken = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_full",     32'(o_full),         0);
    chk("rst_upd_en",   32'(o_update_en),    0);
    chk("rst_upd_idx",  32'(o_update_idx),   0);
    chk("rst_upd_tk",   32'(o_update_taken), 0);
    chk("rst_redirect", 32'(o_redirect),     0);
    chk("rst_flush",    32'(o_flush),        0);
    chk("rst_rpc",      o_redirect_pc,       0);
    chk("rst_err",      32'(o_err),          0);
    chk("rst_br",       o_br_cnt,            0);
    chk("rst_mis",      o_mis_cnt,           0);
    i_rst = 1'b0; i_ex_valid = 1'b0; i_ex_taken = 1'b0;
    mq.delete(); m_red = 1'b0; m_err = 1'b0; m_br = '0; m_mis = '0;
  endtask

  vec_t tv[9];

  initial begin
    ent_t h;
    i_rst = 1'b1; i_pred_valid = 1'b0; i_pred_pc = '0; i_pred_taken = 1'b0;
    i_pred_idx = '0; i_pred_target = '0; i_ex_valid = 1'b0; i_ex_taken = 1'b0;
    i_ex_target = '0;
    mq.delete(); m_red = 1'b0; m_err = 1'b0; m_br = '0; m_mis = '0;
    @(posedge i_clk); #1;
    do_reset();

    //          pv  ppc       pt  pidx    ptgt      ev  et  etgt       upd idx     tk  red rpc
    tv[0] = '{1'b1, 32'h100, 1'b1, 10'h3A, 32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    tv[1] = '{1'b0, 32'h0,   1'b0, 10'h0,  32'h0,   1'b1, 1'b1, 32'h140, 1'b1, 10'h3A, 1'b1, 1'b0, 32'h0};
    tv[2] = '{1'b1, 32'h200, 1'b0, 10'h05, 32'h240, 1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    tv[3] = '{1'b0, 32'h0,   1'b0, 10'h0,  32'h0,   1'b1, 1'b1, 32'h280, 1'b1, 10'h05, 1'b1, 1'b1, 32'h280};
    tv[4] = '{1'b0, 32'h0,   1'b0, 10'h0,  32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    tv[5] = '{1'b1, 32'h300, 1'b1, 10'h11, 32'h340, 1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    tv[6] = '{1'b1, 32'h308, 1'b0, 10'h12, 32'h0,   1'b1, 1'b0, 32'h0,   1'b1, 10'h11, 1'b0, 1'b1, 32'h304};
    tv[7] = '{1'b1, 32'h30C, 1'b0, 10'h13, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    tv[8] = '{1'b0, 32'h0,   1'b0, 10'h0,  32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 10'h0,  1'b0, 1'b0, 32'h0};
    for (int i = 0; i < 9; i++) begin
      step(tv[i].pv, tv[i].ppc, tv[i].pt, tv[i].pidx, tv[i].ptgt,
           tv[i].ev, tv[i].et, tv[i].etgt);
      chk($sformatf("tv%0d_upd", i), 32'(o_update_en), 32'(tv[i].e_upd));
      if (tv[i].e_upd) chk($sformatf("tv%0d_idx", i), 32'(o_update_idx), 32'(tv[i].e_idx));
      chk($sformatf("tv%0d_red", i), 32'(o_redirect), 32'(tv[i].e_red));
      if (tv[i].e_red) chk($sformatf("tv%0d_rpc", i), o_redirect_pc, tv[i].e_rpc);
    end
    // both wrong-path pushes were dropped, so the queue must be empty now
    chk("empty_after_redirect", 32'(o_full), 0);

    // Resolve with nothing in flight: sticky error, no strobe, counters frozen.
    step(1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("err_set", 32'(o_err), 1);
    idle();
    chk("err_sticky", 32'(o_err), 1);

    // Fill to DEPTH, fifth push ignored.
    for (int k = 0; k < DEPTH + 1; k++)
      step(1'b1, 32'h1000 + 32'(k) * 4, k[0], GBIT'(k + 1), 32'h2000 + 32'(k), 1'b0, 1'b0, 32'h0);
    chk("full_after_fill", 32'(o_full), 1);
    // Pop while full with a push: push is refused (no bypass).
    h = mq[0];
    step(1'b1, 32'h1F00, 1'b0, 10'h3FF, 32'h0, 1'b1, h.taken, h.target);
    // Steady push+pop at three entries across three pointer wraps.
    for (int k = 0; k < 12; k++) begin
      h = mq[0];
      step(1'b1, 32'h1100 + 32'(k) * 4, ~k[1], GBIT'(k + 8), 32'h3000 + 32'(k) * 8,
           1'b1, h.taken, h.target);
    end
    step(1'b1, 32'h1200, 1'b1, 10'h2AA, 32'h1234, 1'b0, 1'b0, 32'h0);
    chk("refill_full", 32'(o_full), 1);

    // Random mix of pushes, resolves and mispredicts.
    for (int k = 0; k < 60; k++) begin
      logic ev, et;
      logic [31:0] tgt;
      ev  = ($urandom_range(0, 2) != 0);
      et  = $urandom_range(0, 1) == 1;
      tgt = 32'h5000 + 32'($urandom_range(0, 3)) * 4;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        h = mq[0]; et = h.taken; tgt = h.target;
      end
      step($urandom_range(0, 1) == 1, 32'h8000 + 32'(k) * 4, $urandom_range(0, 1) == 1,
           GBIT'($urandom_range(0, 1023)), 32'h5000 + 32'($urandom_range(0, 3)) * 4,
           ev, et, tgt);
    end

    // Reset mid-operation with three entries in flight.
    do_reset();
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h9000 + 32'(k) * 4, 1'b1, GBIT'(k), 32'h9100, 1'b0, 1'b0, 32'h0);
    do_reset();
    step(1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b1, 1'b1, 32'h9100);
    chk("err_after_reset", 32'(o_err), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
